// File: rtl/jtcop_prot_pkg.sv
// Shared types and helpers for the HuC6280 protection-CPU ROM bus bridge.
package jtcop_prot_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    WAIT,
    DONE
  } state_t;

  // Width of the WAIT-state timeout counter
  localparam int unsigned CNT_W = 8;

  // Pick the byte lane of a 16-bit ROM word from byte-address bit 0
  function automatic logic [7:0] lane_sel(input logic [15:0] word, input logic odd);
    return odd ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/jtcop_prot_rombus.sv
// Byte-to-word bridge between the HuC6280 protection CPU and the 16-bit
// SDRAM ROM slot. CPU reads in the ROM region become word fetches; the CPU
// is stalled through WAIT_N until the SDRAM answers.
// Optional build macro: JTCOP_PROT_CACHE_EN adds a one-word read cache.
module jtcop_prot_rombus
  import jtcop_prot_pkg::*;
#(
  parameter int unsigned AW   = 16,
  parameter int unsigned TOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [20:0]   cpu_addr,
  input  logic          cpu_rdn,
  input  logic          cpu_ce,
  input  logic          rom_sel,
  output logic [7:0]    cpu_din,
  output logic          cpu_waitn,
  output logic          rom_cs,
  output logic [AW-2:0] rom_addr,
  input  logic [15:0]   rom_data,
  input  logic          rom_ok,
  output logic          rom_err
);

  localparam logic [CNT_W-1:0] TOUT_C = CNT_W'(TOUT);

  state_t           state, state_nx;
  logic [20:0]      addr_q;
  logic [15:0]      word_buf;
  logic             waitn_q;
  logic [CNT_W-1:0] cnt;
  logic             req;
  logic             hit;

  assign req      = cpu_ce & rom_sel & ~cpu_rdn;
  assign rom_addr = addr_q[AW-1:1];

`ifdef JTCOP_PROT_CACHE_EN
  logic valid;

  assign hit = valid && (cpu_addr[AW-1:1] == addr_q[AW-1:1]);

  // Cache valid: dropped when a new fetch overwrites the tag, set on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else begin
      if (state == IDLE && req && !hit) valid <= 1'b0;
      else if (state == WAIT && rom_ok)  valid <= 1'b1;
    end
  end
`else
  assign hit = 1'b0;
`endif

  // Next-state decode plus the combinational CPU-facing outputs
  always_comb begin
    state_nx  = state;
    cpu_waitn = waitn_q;
    cpu_din   = lane_sel(word_buf, addr_q[0]);
    case (state)
      IDLE: begin
        // Wait must fall in the very cycle the miss is first seen
        cpu_waitn = !(rst_n && req && !hit);
        if (req) begin
          state_nx = hit ? DONE : SETTLE;
          if (hit) cpu_din = lane_sel(word_buf, cpu_addr[0]);
        end
      end
      SETTLE: state_nx = WAIT;
      WAIT:   if (rom_ok) state_nx = DONE;
      DONE:   if (cpu_rdn || (cpu_addr != addr_q)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register, request/handshake registers, word buffer and timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      word_buf <= '0;
      waitn_q  <= 1'b1;
      rom_cs   <= 1'b0;
      cnt      <= '0;
      rom_err  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (req) begin
            addr_q <= cpu_addr;
            if (!hit) begin
              rom_cs  <= 1'b1;
              waitn_q <= 1'b0;
            end
          end
        end
        SETTLE: cnt <= '0;
        WAIT: begin
          if (rom_ok) begin
            word_buf <= rom_data;
            rom_cs   <= 1'b0;
            waitn_q  <= 1'b1;
          end else begin
            if (cnt != TOUT_C) cnt <= cnt + 1'b1;
            // Flag lands together with the counter reaching TOUT
            if (cnt >= TOUT_C - 1'b1) rom_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jtcop_prot_rombus.sv
// Directed bench for jtcop_prot_rombus: table of read transactions plus
// hand-written sequences for stale ok, timeout, reset and non-ROM traffic.
module tb_jtcop_prot_rombus;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [20:0] cpu_addr = '0;
  logic        cpu_rdn = 1'b1;
  logic        cpu_ce = 1'b0;
  logic        rom_sel = 1'b0;
  logic [7:0]  cpu_din;
  logic        cpu_waitn;
  logic        rom_cs;
  logic [14:0] rom_addr;
  logic [15:0] rom_data = '0;
  logic        rom_ok = 1'b0;
  logic        rom_err;

  int checks = 0;
  int failures = 0;

`ifdef JTCOP_PROT_CACHE_EN
  localparam bit CACHED = 1'b1;
`else
  localparam bit CACHED = 1'b0;
`endif

  jtcop_prot_rombus #(.AW(16), .TOUT(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_addr (cpu_addr),
    .cpu_rdn  (cpu_rdn),
    .cpu_ce   (cpu_ce),
    .rom_sel  (rom_sel),
    .cpu_din  (cpu_din),
    .cpu_waitn(cpu_waitn),
    .rom_cs   (rom_cs),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .rom_ok   (rom_ok),
    .rom_err  (rom_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [20:0] addr;
    logic [15:0] data;
    int          dly;    // cycles from rom_cs rising to rom_ok
    logic [14:0] raddr;
    logic [7:0]  din;
    bit          hit;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled mid-cycle
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic release_bus();
    next_cycle();
    cpu_rdn = 1'b1;
    next_cycle();
  endtask

  // One CPU read; entered and left at the start of an IDLE cycle
  task automatic do_read(input vec_t v);
    int k;
    cpu_addr = v.addr;
    cpu_rdn  = 1'b0;
    cpu_ce   = 1'b1;
    rom_sel  = 1'b1;
    rom_ok   = 1'b0;
    if (v.hit) begin
      mid();
      chk({v.name, "_hit_waitn"}, 32'(cpu_waitn), 32'd1);
      chk({v.name, "_hit_cs"}, 32'(rom_cs), 32'd0);
      chk({v.name, "_hit_din"}, 32'(cpu_din), 32'(v.din));
      next_cycle();
      mid();
      chk({v.name, "_done_din"}, 32'(cpu_din), 32'(v.din));
    end else begin
      k = 1 + v.dly;
      for (int c = 0; c <= k; c++) begin
        rom_ok   = (c == k);
        rom_data = (c == k) ? v.data : ~v.data;
        mid();
        chk({v.name, "_waitn_low"}, 32'(cpu_waitn), 32'd0);
        chk({v.name, "_cs"}, 32'(rom_cs), (c >= 1) ? 32'd1 : 32'd0);
        if (c >= 1) chk({v.name, "_raddr"}, 32'(rom_addr), 32'(v.raddr));
        next_cycle();
      end
      rom_ok   = 1'b0;
      rom_data = 16'h0;
      mid();
      chk({v.name, "_waitn_rise"}, 32'(cpu_waitn), 32'd1);
      chk({v.name, "_cs_drop"}, 32'(rom_cs), 32'd0);
      chk({v.name, "_din"}, 32'(cpu_din), 32'(v.din));
    end
    release_bus();
  endtask

  initial begin
    vec_t v;

    tbl[0] = '{"miss_even", 21'h00122, 16'hBEEF, 4, 15'h0091, 8'hEF, 1'b0};
    tbl[1] = '{"odd_byte",  21'h00123, 16'hBEEF, 2, 15'h0091, 8'hBE, CACHED};
    tbl[2] = '{"miss_fast", 21'h00400, 16'h1234, 1, 15'h0200, 8'h34, 1'b0};
    tbl[3] = '{"top_word",  21'h1FFFF, 16'hA55A, 3, 15'h7FFF, 8'hA5, 1'b0};
    tbl[4] = '{"refetch",   21'h00401, 16'h9876, 1, 15'h0200, 8'h98, 1'b0};

    // Reset state
    #12;
    chk("rst_cs", 32'(rom_cs), 32'd0);
    chk("rst_waitn", 32'(cpu_waitn), 32'd1);
    chk("rst_din", 32'(cpu_din), 32'd0);
    chk("rst_err", 32'(rom_err), 32'd0);
    chk("rst_raddr", 32'(rom_addr), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    next_cycle();

    for (int i = 0; i < 5; i++) do_read(tbl[i]);

    // Stale ok held through SETTLE must not complete the fetch early
    cpu_addr = 21'h00500;
    cpu_rdn  = 1'b0;
    rom_ok   = 1'b1;
    rom_data = 16'hC0DE;
    mid(); chk("stale_c0_waitn", 32'(cpu_waitn), 32'd0);
    next_cycle();
    mid(); chk("stale_c1_waitn", 32'(cpu_waitn), 32'd0);
    chk("stale_c1_cs", 32'(rom_cs), 32'd1);
    next_cycle();
    mid(); chk("stale_c2_waitn", 32'(cpu_waitn), 32'd0);
    next_cycle();
    mid(); chk("stale_c3_waitn", 32'(cpu_waitn), 32'd1);
    chk("stale_c3_din", 32'(cpu_din), 32'hDE);
    rom_ok = 1'b0;
    release_bus();

    // Timeout: no ok until cycle 15, TOUT=10
    cpu_addr = 21'h00600;
    cpu_rdn  = 1'b0;
    for (int c = 0; c <= 15; c++) begin
      rom_ok   = (c == 15);
      rom_data = (c == 15) ? 16'h4242 : 16'h0;
      mid();
      if (c == 11) chk("tout_c11_err", 32'(rom_err), 32'd0);
      if (c == 12) begin
        chk("tout_c12_err", 32'(rom_err), 32'd1);
        chk("tout_c12_waitn", 32'(cpu_waitn), 32'd0);
      end
      if (c == 14) chk("tout_c14_cs", 32'(rom_cs), 32'd1);
      next_cycle();
    end
    rom_ok = 1'b0;
    mid();
    chk("tout_done_waitn", 32'(cpu_waitn), 32'd1);
    chk("tout_done_din", 32'(cpu_din), 32'h42);
    chk("tout_err_sticky", 32'(rom_err), 32'd1);
    release_bus();

    // Reset while idle with the 0x600 word cached: the reread must miss
    rst_n = 1'b0;
    #1;
    chk("rsti_err", 32'(rom_err), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    v = '{"rst_idle_reread", 21'h00601, 16'h7788, 1, 15'h0300, 8'h77, 1'b0};
    do_read(v);

    // Reset asserted mid-fetch, during WAIT
    cpu_addr = 21'h00800;
    cpu_rdn  = 1'b0;
    next_cycle(); next_cycle(); next_cycle();
    rst_n = 1'b0;
    #1;
    chk("rstw_cs", 32'(rom_cs), 32'd0);
    chk("rstw_waitn", 32'(cpu_waitn), 32'd1);
    chk("rstw_din", 32'(cpu_din), 32'd0);
    chk("rstw_raddr", 32'(rom_addr), 32'd0);
    next_cycle();
    rst_n   = 1'b1;
    cpu_rdn = 1'b1;
    next_cycle();
    v = '{"rst_wait_reread", 21'h00800, 16'h5AA5, 2, 15'h0400, 8'hA5, 1'b0};
    do_read(v);

    // Non-ROM reads, ROM-region writes and ce-low cycles never fetch or stall
    cpu_addr = 21'h00122;
    rom_ok   = 1'b1;
    cpu_ce   = 1'b1;
    rom_sel  = 1'b0;
    cpu_rdn  = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c == 3) begin rom_sel = 1'b1; cpu_rdn = 1'b1; end
      if (c == 6) begin cpu_ce = 1'b0; cpu_rdn = 1'b0; end
      mid();
      chk("traffic_cs", 32'(rom_cs), 32'd0);
      chk("traffic_waitn", 32'(cpu_waitn), 32'd1);
      next_cycle();
    end
    rom_ok = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
